irq_pending_ctrl: RTL and testbench

Interrupt front end that feeds the 8-to-3 priority encoder stage. It synchronizes eight asynchronous request lines and rising-edge-detects them into a sticky pending register. It applies a mask, uses `priority_encoder_8_to_3` to select the winning line, and presents that line's 3-bit ID on a valid/ack handshake. It sits between external event sources and the consumer that services one interrupt ID at a time.

---
 rtl/irq_pkg.sv | 19 +
 rtl/priority_encoder_8_to_3.sv | 21 ++
 rtl/irq_pending_ctrl.sv | 116 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
//   IRQ_W / IRQ_ID_W : request-line count and ID width (8-to-3 encoding)
//   irq_state_t      : presentation FSM states
//   onehot8()        : builds the pending-clear vector from a presented ID
package irq_pkg;

    localparam int IRQ_W    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    function automatic logic [IRQ_W-1:0] onehot8(input logic [IRQ_ID_W-1:0] id);
        onehot8 = IRQ_W'(1) << id;
    endfunction

endpackage

// File: rtl/priority_encoder_8_to_3.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
//   req : request vector
//   idx : index of the highest set bit (0 when req is zero)
//   any : at least one request bit is set
module priority_encoder_8_to_3 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < 8; i++) begin
            if (req[i]) idx = 3'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronizes eight asynchronous request lines, edge
// detects them into a sticky pending register, masks, priority-selects and
// presents one interrupt ID at a time on a valid/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq_in     : raw asynchronous request lines (rising edge = one event)
//   irq_mask   : 1 makes a line ineligible for presentation
//   irq_valid  : an ID is being presented
//   irq_id     : presented ID, meaningful while irq_valid
//   irq_ack    : consumer accepts the presented ID
//   pending    : registered pending bits (unmasked) for status readback
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_W,  // fixed by the 8-to-3 encoder
    parameter int SYNC_STAGES = 2       // legal range 2..3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_ack,
    output logic [NUM_IRQ-1:0]  pending
);

    logic [NUM_IRQ-1:0]  sync;
    logic [NUM_IRQ-1:0]  prev;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  clr;
    logic [NUM_IRQ-1:0]  elig;
    logic [IRQ_ID_W-1:0] enc_idx;
    logic                enc_any;

    irq_state_t          state, state_next;
    logic                valid_next;
    logic [IRQ_ID_W-1:0] id_next;

    // Per-line synchronizer chain; the last stage feeds edge detection.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], irq_in[i]};
        end

        assign sync[i] = chain[SYNC_STAGES-1];
    end

    // prev clears on reset, so a line held high through reset release
    // produces exactly one rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= sync;
    end

    assign rise = sync & ~prev;

    // Set wins over clear: a new edge on the acked line is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr) | rise;
    end

    assign elig = pending & ~irq_mask;

    priority_encoder_8_to_3 u_enc (
        .req (elig),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Presentation FSM: the ID is captured once in IDLE and held frozen in
    // PRESENT regardless of new events or mask changes until acked.
    always_comb begin
        state_next = state;
        valid_next = irq_valid;
        id_next    = irq_id;
        clr        = '0;
        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (enc_any) begin
                    state_next = PRESENT;
                    valid_next = 1'b1;
                    id_next    = enc_idx;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    clr        = onehot8(irq_id);
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            state     <= state_next;
            irq_valid <= valid_next;
            irq_id    <= id_next;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // Expected IDs in order of presentation.
    int unsigned exp_q[$];

    irq_pending_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for irq_valid, sampled on falling edges.
    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!irq_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!irq_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: irq_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic do_ack(input string name);
        wait_valid(name);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v, input int len);
        irq_in = v;
        tick(len);
        irq_in = 8'h00;
    endtask

    // Monitor: every new presentation pops the next expected ID.
    logic was_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            was_valid = 1'b0;
        end else begin
            if (irq_valid && !was_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got id %0d expected no presentation", irq_id);
                end else begin
                    check("sb_id", 32'(irq_id), exp_q.pop_front());
                end
            end
            was_valid = irq_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        irq_in   = 8'h00;
        irq_mask = 8'h00;
        irq_ack  = 1'b0;
        #3;
        check("rst_valid",   32'(irq_valid), 0);
        check("rst_id",      32'(irq_id),    0);
        check("rst_pending", 32'(pending),   0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Single event and latency.
        exp_q.push_back(2);
        irq_in = 8'h04;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        check("t1_valid_early", 32'(irq_valid), 0);
        check("t1_pending_set", 32'(pending), 32'h04);
        tick(1);
        check("t1_valid_on_time", 32'(irq_valid), 1);
        check("t1_id", 32'(irq_id), 2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t1_valid_after_ack", 32'(irq_valid), 0);
        check("t1_pending_clr", 32'(pending), 32'h00);
        tick(3);

        // Priority and freeze.
        exp_q.push_back(6);
        pulse(8'h42, 2);
        wait_valid("t2_wait6");
        pulse(8'h80, 2);
        tick(5);
        check("t2_frozen_id", 32'(irq_id), 6);
        check("t2_frozen_valid", 32'(irq_valid), 1);
        check("t2_pending", 32'(pending), 32'hC2);
        exp_q.push_back(7);
        exp_q.push_back(1);
        do_ack("t2_ack6");
        check("t2_dead_cycle", 32'(irq_valid), 0);
        tick(1);
        check("t2_next_valid", 32'(irq_valid), 1);
        check("t2_next_id", 32'(irq_id), 7);
        do_ack("t2_ack7");
        check("t2_dead_cycle2", 32'(irq_valid), 0);
        do_ack("t2_ack1");
        check("t2_pending_empty", 32'(pending), 0);
        tick(3);

        // Mask.
        irq_mask = 8'h80;
        exp_q.push_back(0);
        pulse(8'h81, 2);
        wait_valid("t3_wait0");
        check("t3_id", 32'(irq_id), 0);
        check("t3_pending", 32'(pending), 32'h81);
        do_ack("t3_ack0");
        check("t3_pending_after", 32'(pending), 32'h80);
        tick(3);
        check("t3_masked_idle", 32'(irq_valid), 0);
        exp_q.push_back(7);
        irq_mask = 8'h00;
        wait_valid("t3_wait7");
        check("t3_id7", 32'(irq_id), 7);
        do_ack("t3_ack7");
        tick(3);

        // Set-wins: new bit-3 rise lands on the ack clock.
        exp_q.push_back(3);
        pulse(8'h08, 2);
        wait_valid("t4_wait3");
        tick(4);
        irq_in = 8'h08;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        irq_ack = 1'b1;
        exp_q.push_back(3);
        tick(1);
        irq_ack = 1'b0;
        check("t4_valid_after_ack", 32'(irq_valid), 0);
        check("t4_pending_kept", 32'(pending), 32'h08);
        do_ack("t4_ack3b");
        check("t4_pending_clr", 32'(pending), 0);
        tick(3);

        // Spurious ack in IDLE and edge merge.
        irq_mask = 8'hFF;
        pulse(8'h10, 2);
        tick(5);
        check("t5_pending_masked", 32'(pending), 32'h10);
        irq_ack = 1'b1;
        tick(2);
        irq_ack = 1'b0;
        check("t5_spurious_pending", 32'(pending), 32'h10);
        check("t5_spurious_valid", 32'(irq_valid), 0);
        for (int i = 0; i < 3; i++) begin
            pulse(8'h20, 2);
            tick(2);
        end
        tick(3);
        check("t5_merge_pending", 32'(pending), 32'h30);
        exp_q.push_back(5);
        exp_q.push_back(4);
        irq_mask = 8'h00;
        do_ack("t5_ack5");
        do_ack("t5_ack4");
        check("t5_pending_clr", 32'(pending), 0);
        tick(5);

        // Reset mid-PRESENT.
        exp_q.push_back(7);
        pulse(8'hFF, 2);
        wait_valid("t6_wait7");
        tick(2);
        check("t6_pending_full", 32'(pending), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",   32'(irq_valid), 0);
        check("t6_rst_id",      32'(irq_id),    0);
        check("t6_rst_pending", 32'(pending),   0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("t6_no_valid", 32'(irq_valid), 0);
        check("t6_no_pending", 32'(pending), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
